// File: rtl/pc_next_unit_if.sv
// Request and status bundle for the pc_next_unit.
// Master drives stall/redirect requests; slave owns the PC.
interface pc_next_unit_if;
  logic        Stall;
  logic        Branch;
  logic        Jump;
  logic [31:0] BranchOffset;
  logic [25:0] JumpIndex;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] BranchTarget;
  logic        Redirect;
  logic        DelayPending;

  modport master (
    output Stall, Branch, Jump,
    output BranchOffset, JumpIndex,
    input  PC, PCPlus4, BranchTarget,
    input  Redirect, DelayPending
  );

  modport slave (
    input  Stall, Branch, Jump,
    input  BranchOffset, JumpIndex,
    output PC, PCPlus4, BranchTarget,
    output Redirect, DelayPending
  );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC selection with jump/branch redirect.
// Define BRANCH_DELAY_SLOT_EN for one-slot delayed redirects.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            Clk,
  input logic            Rst,
  pc_next_unit_if.slave  bus
);
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic [31:0] tgt;
  logic        req;
  logic        redir_q;

  assign pc4  = pc_q + 32'd4;
  assign btgt = pc4 + bus.BranchOffset;
  assign jtgt = {pc4[31:28], bus.JumpIndex, 2'b00};
  // jump beats branch; low bits always forced to word alignment
  assign tgt  = bus.Jump ? jtgt : {btgt[31:2], 2'b00};
  assign req  = bus.Jump | bus.Branch;

  assign bus.PC           = pc_q;
  assign bus.PCPlus4      = pc4;
  assign bus.BranchTarget = btgt;
  assign bus.Redirect     = redir_q;

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {IDLE, PENDING} state_t;

  state_t      st_q;
  logic [31:0] tgt_q;
  logic        dp_q;

  assign bus.DelayPending = dp_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RST_PC;
      redir_q <= 1'b0;
      dp_q    <= 1'b0;
      tgt_q   <= '0;
      st_q    <= IDLE;
    end else if (!bus.Stall) begin
      unique case (st_q)
        IDLE: begin
          pc_q    <= {pc4[31:2], 2'b00};
          redir_q <= 1'b0;
          if (req) begin
            tgt_q <= tgt;
            dp_q  <= 1'b1;
            st_q  <= PENDING;
          end
        end
        PENDING: begin
          // requests in the delay slot are dropped
          pc_q    <= tgt_q;
          redir_q <= 1'b1;
          dp_q    <= 1'b0;
          st_q    <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
`else
  assign bus.DelayPending = 1'b0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RST_PC;
      redir_q <= 1'b0;
    end else if (!bus.Stall) begin
      if (req) begin
        pc_q    <= tgt;
        redir_q <= 1'b1;
      end else begin
        pc_q    <= {pc4[31:2], 2'b00};
        redir_q <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] are ignored and treated as 00.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 Stall  input  1  when high, all state holds on that edge.
REQ-005 Branch  input  1  taken-branch request for the instruction at the current PC.
REQ-006 Jump  input  1  jump request for the instruction at the current PC.
REQ-007 BranchOffset  input  32  sign-extended word offset, already shifted left by 2 upstream; used as-is.
REQ-008 JumpIndex  input  26  jump instruction index field.
REQ-009 PC  output  32  registered program counter.
REQ-010 PCPlus4  output  32  combinational PC + 4.
REQ-011 BranchTarget  output  32  combinational PCPlus4 + BranchOffset.
REQ-012 Redirect  output  1  registered; high while PC holds a non-sequential target.
REQ-013 DelayPending  output  1  registered; high while a delay-slot redirect is outstanding.

Function
REQ-014 PCPlus4 and BranchTarget SHALL be 32-bit sums that wrap modulo 2^32, with no overflow flag.
REQ-015 Jump target SHALL be {PCPlus4[31:28], JumpIndex, 2'b00}.
REQ-016 PC[1:0] SHALL always read 00; the adder results use bits [31:2] only for the PC load.
REQ-017 Edge priority SHALL be: Rst, then Stall, then Jump, then Branch, then sequential (PC <= PCPlus4).
REQ-018 With Stall high, PC, Redirect, DelayPending and any latched target SHALL hold regardless of Branch or Jump.
REQ-019 An accepted edge is any rising edge with Rst=0 and Stall=0; Branch and Jump are sampled only on accepted edges.
REQ-020 Redirect SHALL be set on an accepted edge that loads PC with a jump or branch target, and cleared on the next accepted edge that loads a sequential value.
REQ-021 When Jump and Branch are both high, Jump SHALL win and Branch SHALL be discarded.

Reset
REQ-022 On a Clk edge with Rst=1, the block SHALL set PC to {RESET_PC[31:2],2'b00}, set Redirect to 0, set DelayPending to 0, and clear the latched target, regardless of Stall or any request.
REQ-023 Reset during a pending delay-slot redirect SHALL discard the redirect.

Configuration
REQ-024 Macro BRANCH_DELAY_SLOT_EN selects the redirect timing.
REQ-025 Without BRANCH_DELAY_SLOT_EN:
- an accepted Jump or Branch loads its target into PC on that same edge (one-cycle redirect);
- DelayPending is tied to 0.
REQ-026 With BRANCH_DELAY_SLOT_EN, a two-state FSM (IDLE, PENDING) SHALL operate as follows:
- In IDLE, an accepted Jump or Branch latches its target, loads PC <= PCPlus4 (the delay slot), sets DelayPending and moves to PENDING.
- In PENDING, the next accepted edge loads PC <= latched target, sets Redirect, clears DelayPending and returns to IDLE.
- In PENDING, Branch and Jump SHALL be ignored (a branch in a delay slot is unsupported).
- Stall holds the FSM in its current state.

Verification
REQ-027 Rst=1 with RESET_PC=32'h0000_0403 -> PC=32'h0000_0400, Redirect=0, DelayPending=0 next cycle.
REQ-028 PC=0x100, Branch=1, BranchOffset=0xFFFF_FFF0, macro off -> PC=0x0F4, Redirect=1; next edge with no request -> PC=0x0F8, Redirect=0.
REQ-029 PC=0xFFFF_FFFC, no request -> PC=0x0000_0000 (wrap); BranchOffset=0x8 -> BranchTarget=0x0000_0008.
REQ-030 PC=0x1000_0000, Jump=1, Branch=1, JumpIndex=26'h000_0040 -> PC=0x1000_0100 (Jump wins).
REQ-031 Macro on, PC=0x200, Branch=1, BranchOffset=0x40 -> PC=0x204, DelayPending=1; Stall=1 for 2 cycles -> PC and DelayPending hold; next accepted edge with Branch=1 -> PC=0x244, DelayPending=0 (second branch ignored).
REQ-032 Macro on, Rst=1 while DelayPending=1 -> PC=RESET_PC, DelayPending=0; following accepted edge -> PC=RESET_PC+4.
